// File: rtl/adc_sched_pkg.sv
// Shared constants and FSM state encoding for the ADC scan scheduler.
package adc_sched_pkg;

  localparam int ADC_W       = 12;
  localparam int OVR_W       = 8;
  localparam int DEF_PERIOD  = 50000;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_START     = 3'd2,
    ST_CONVERT   = 3'd3,
    ST_PUSH      = 3'd4
  } sched_state_e;

endpackage

// File: rtl/adc_tick_timer.sv
// Free-running period counter; tick pulses for one cycle at count PERIOD-1.
module adc_tick_timer
  import adc_sched_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!enable || (count_q == CNT_LAST)) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = enable && (count_q == CNT_LAST);

endmodule

// File: rtl/adc_scan_scheduler.sv
// Periodic round-robin ADC scan: requests conversions, captures results into
// per-channel registers and streams each sample to the collector.
module adc_scan_scheduler
  import adc_sched_pkg::*;
#(
  parameter int PERIOD  = DEF_PERIOD,
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              conv_start,
  output logic [CH_W-1:0]   conv_chan,
  input  logic              conv_done,
  input  logic [ADC_W-1:0]  conv_data,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [CH_W-1:0]   smp_chan,
  output logic [ADC_W-1:0]  smp_data,
  input  logic [CH_W-1:0]   rd_chan,
  output logic [ADC_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic [OVR_W-1:0]  overrun_cnt,
  output logic              timeout_err
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  sched_state_e      state_q, state_d;
  logic [CH_W-1:0]   conv_chan_q, conv_chan_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]   smp_chan_q, smp_chan_d;
  logic [ADC_W-1:0]  smp_data_q, smp_data_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic              tmo_err_q, tmo_err_d;
  logic              conv_start_q;
  logic              capture;
  logic              tick;
  logic [ADC_W-1:0]  result_q [NUM_CH];
  logic [NUM_CH-1:0] valid_q;

  // First set mask bit strictly after 'last', wrapping around.
  function automatic logic [CH_W-1:0] pick_next(input logic [NUM_CH-1:0] mask,
                                                input logic [CH_W-1:0]   last);
    logic [CH_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last) + i) % NUM_CH;
      if (!found && mask[idx]) begin
        sel   = idx[CH_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  adc_tick_timer #(.PERIOD(PERIOD)) u_tick_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    conv_chan_d = conv_chan_q;
    last_d      = last_q;
    smp_chan_d  = smp_chan_q;
    smp_data_d  = smp_data_q;
    tmo_d       = tmo_q;
    tmo_err_d   = tmo_err_q;
    ovr_d       = ovr_q;
    capture     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tick && (ch_mask != '0)) begin
          conv_chan_d = pick_next(ch_mask, last_q);
          last_d      = conv_chan_d;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        tmo_d   = '0;
        state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        // A conv_done coinciding with the last timeout cycle still counts.
        if (conv_done) begin
          capture    = 1'b1;
          smp_data_d = conv_data;
          smp_chan_d = conv_chan_q;
          state_d    = ST_PUSH;
        end else if (tmo_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = ST_WAIT_TICK;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_PUSH: begin
        if (smp_ready) state_d = enable ? ST_WAIT_TICK : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Ticks while a conversion is in flight are dropped and counted.
    if (tick && (state_q inside {ST_START, ST_CONVERT, ST_PUSH}) && (ovr_q != '1)) begin
      ovr_d = ovr_q + OVR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      conv_chan_q  <= '0;
      last_q       <= CH_W'(NUM_CH - 1);
      smp_chan_q   <= '0;
      smp_data_q   <= '0;
      tmo_q        <= '0;
      tmo_err_q    <= 1'b0;
      ovr_q        <= '0;
      conv_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      conv_chan_q  <= conv_chan_d;
      last_q       <= last_d;
      smp_chan_q   <= smp_chan_d;
      smp_data_q   <= smp_data_d;
      tmo_q        <= tmo_d;
      tmo_err_q    <= tmo_err_d;
      ovr_q        <= ovr_d;
      conv_start_q <= (state_q == ST_START);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        result_q[gi] <= '0;
        valid_q[gi]  <= 1'b0;
      end else if (capture && (conv_chan_q == CH_W'(gi))) begin
        result_q[gi] <= conv_data;
        valid_q[gi]  <= 1'b1;
      end
    end
  end

  assign conv_start  = conv_start_q;
  assign conv_chan   = conv_chan_q;
  assign smp_valid   = (state_q == ST_PUSH);
  assign smp_chan    = smp_chan_q;
  assign smp_data    = smp_data_q;
  assign overrun_cnt = ovr_q;
  assign timeout_err = tmo_err_q;
  assign rd_data     = result_q[rd_chan];
  assign rd_valid    = valid_q[rd_chan];

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Self-checking bench for adc_scan_scheduler: ADC engine model plus a
// scoreboard of expected channels and streamed samples.
module tb_adc_scan_scheduler;

  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 1024;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        enable    = 1'b0;
  logic [3:0]  ch_mask   = 4'hF;
  logic        conv_start;
  logic [1:0]  conv_chan;
  logic        conv_done = 1'b0;
  logic [11:0] conv_data = 12'h000;
  logic        smp_valid;
  logic        smp_ready = 1'b1;
  logic [1:0]  smp_chan;
  logic [11:0] smp_data;
  logic [1:0]  rd_chan   = 2'd0;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic [7:0]  overrun_cnt;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          eng_delay = 616;
  bit          eng_on    = 1'b1;
  logic [11:0] eng_val   = 12'hA5C;
  int          eng_cnt   = 0;
  bit          eng_busy  = 1'b0;
  logic [1:0]  eng_ch    = 2'd0;

  logic [1:0]  exp_ch_q[$];
  logic [13:0] exp_smp_q[$];
  int          start_cyc_q[$];
  int          n_start  = 0;
  int          n_xfer   = 0;
  bit          lat_chk  = 1'b0;
  int          lat_base = 0;

  adc_scan_scheduler #(
    .PERIOD  (PERIOD),
    .NUM_CH  (4),
    .CH_W    (2),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .ch_mask     (ch_mask),
    .conv_start  (conv_start),
    .conv_chan   (conv_chan),
    .conv_done   (conv_done),
    .conv_data   (conv_data),
    .smp_valid   (smp_valid),
    .smp_ready   (smp_ready),
    .smp_chan    (smp_chan),
    .smp_data    (smp_data),
    .rd_chan     (rd_chan),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .overrun_cnt (overrun_cnt),
    .timeout_err (timeout_err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model and scoreboard; drives conv_done and samples DUT outputs at negedge.
  always @(negedge clk) begin : monitor
    logic [1:0]  ech;
    logic [13:0] es;
    if (!rst) begin
      conv_done = 1'b0;
      eng_busy  = 1'b0;
    end else begin
      conv_done = 1'b0;
      if (eng_busy) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_busy  = 1'b0;
          conv_done = 1'b1;
          conv_data = eng_val;
          exp_smp_q.push_back({eng_ch, eng_val});
        end
      end
      if (conv_start === 1'b1) begin
        n_start++;
        start_cyc_q.push_back(cyc);
        checks++;
        ech = 2'd0;
        if (exp_ch_q.size() == 0) begin
          errors++;
          $display("FAIL start_chan: conv_start on chan %0d at cycle %0d, required no conversion", conv_chan, cyc);
        end else begin
          ech = exp_ch_q.pop_front();
          if (conv_chan !== ech) begin
            errors++;
            $display("FAIL start_chan: conv_chan=%0d, required %0d", conv_chan, ech);
          end
        end
        eng_ch = ech;
        if (lat_chk) begin
          checks++;
          if ((cyc - lat_base < 101) || ((cyc - lat_base - 101) % PERIOD != 0)) begin
            errors++;
            $display("FAIL start_latency: conv_start %0d cycles after enable, required 101+100k (tick+2)", cyc - lat_base);
          end
        end
        if (eng_on) begin
          eng_busy = 1'b1;
          eng_cnt  = eng_delay;
        end
      end
      if (smp_valid === 1'b1 && smp_ready === 1'b1) begin
        n_xfer++;
        checks++;
        if (exp_smp_q.size() == 0) begin
          errors++;
          $display("FAIL smp_xfer: chan=%0d data=%h transferred, required no sample", smp_chan, smp_data);
        end else begin
          es = exp_smp_q.pop_front();
          if ({smp_chan, smp_data} !== es) begin
            errors++;
            $display("FAIL smp_xfer: chan=%0d data=%h, required chan=%0d data=%h", smp_chan, smp_data, es[13:12], es[11:0]);
          end
        end
      end
    end
  end

  task automatic drive_slot;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfer(input int n, input int budget);
    int i = 0;
    while (n_xfer < n && i < budget) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic wait_start(input int n, input int budget);
    int i = 0;
    while (n_start < n && i < budget) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic wait_valid(input int budget);
    int i = 0;
    while (smp_valid !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic do_reset;
    drive_slot;
    rst       = 1'b0;
    enable    = 1'b0;
    smp_ready = 1'b1;
    ch_mask   = 4'hF;
    eng_on    = 1'b1;
    lat_chk   = 1'b0;
    rd_chan   = 2'd0;
    repeat (3) @(negedge clk);
    exp_ch_q.delete();
    exp_smp_q.delete();
    start_cyc_q.delete();
    n_start = 0;
    n_xfer  = 0;
    drive_slot;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({conv_start, conv_chan, smp_valid, smp_chan, smp_data} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b chan=%0d valid=%b schan=%0d sdata=%h, required all 0",
               conv_start, conv_chan, smp_valid, smp_chan, smp_data);
    end
    checks++;
    if (overrun_cnt !== 8'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: overrun=%0d timeout_err=%b, required 0/0", overrun_cnt, timeout_err);
    end
    for (int ch = 0; ch < 4; ch++) begin
      rd_chan = 2'(ch);
      #1;
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== 12'h000) begin
        errors++;
        $display("FAIL reset_rd ch%0d: valid=%b data=%h, required 0/000", ch, rd_valid, rd_data);
      end
    end
    drive_slot;
    rst = 1'b1;
  endtask

  task automatic test_round_robin;
    do_reset;
    drive_slot;
    eng_delay = 616;
    eng_val   = 12'hA5C;
    for (int i = 0; i < 5; i++) exp_ch_q.push_back(2'(i % 4));
    enable   = 1'b1;
    lat_base = cyc;
    lat_chk  = 1'b1;
    wait_xfer(5, 4500);
    checks++;
    if (n_xfer !== 5 || n_start !== 5) begin
      errors++;
      $display("FAIL rr_count: %0d starts %0d transfers, required 5/5", n_start, n_xfer);
    end
    for (int i = 0; i < 5 && i < start_cyc_q.size(); i++) begin
      checks++;
      if (start_cyc_q[i] - lat_base != 101 + 700 * i) begin
        errors++;
        $display("FAIL rr_start_time #%0d: %0d cycles after enable, required %0d", i, start_cyc_q[i] - lat_base, 101 + 700 * i);
      end
    end
    checks++;
    if (overrun_cnt !== 8'd30) begin
      errors++;
      $display("FAIL rr_overrun: overrun_cnt=%0d, required 30", overrun_cnt);
    end
    drive_slot;
    enable  = 1'b0;
    lat_chk = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      rd_chan = 2'(ch);
      #1;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 12'hA5C) begin
        errors++;
        $display("FAIL rr_rd ch%0d: valid=%b data=%h, required 1/a5c", ch, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_mask;
    do_reset;
    drive_slot;
    ch_mask   = 4'b1010;
    eng_delay = 50;
    eng_val   = 12'h3C1;
    exp_ch_q.push_back(2'd1);
    exp_ch_q.push_back(2'd3);
    exp_ch_q.push_back(2'd1);
    exp_ch_q.push_back(2'd3);
    enable   = 1'b1;
    lat_base = cyc;
    lat_chk  = 1'b1;
    wait_xfer(4, 1000);
    checks++;
    if (n_xfer !== 4) begin
      errors++;
      $display("FAIL mask_count: %0d transfers, required 4", n_xfer);
    end
    drive_slot;
    enable  = 1'b0;
    lat_chk = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      rd_chan = 2'(ch);
      #1;
      checks++;
      if (ch % 2 == 1) begin
        if (rd_valid !== 1'b1 || rd_data !== 12'h3C1) begin
          errors++;
          $display("FAIL mask_rd ch%0d: valid=%b data=%h, required 1/3c1", ch, rd_valid, rd_data);
        end
      end else if (rd_valid !== 1'b0 || rd_data !== 12'h000) begin
        errors++;
        $display("FAIL mask_rd ch%0d: valid=%b data=%h, required 0/000", ch, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    drive_slot;
    smp_ready = 1'b0;
    eng_delay = 10;
    eng_val   = 12'h7E1;
    exp_ch_q.push_back(2'd0);
    enable = 1'b1;
    wait_valid(300);
    checks++;
    if (smp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid_rise: smp_valid=%b, required 1", smp_valid);
    end
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (smp_valid !== 1'b1 || smp_data !== 12'h7E1 || smp_chan !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b chan=%0d data=%h, required 1/0/7e1", i, smp_valid, smp_chan, smp_data);
      end
      @(negedge clk);
    end
    checks++;
    if (n_xfer !== 0) begin
      errors++;
      $display("FAIL bp_no_early_xfer: %0d transfers, required 0", n_xfer);
    end
    drive_slot;
    smp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (smp_valid !== 1'b0 || n_xfer !== 1) begin
      errors++;
      $display("FAIL bp_release: valid=%b transfers=%0d, required 0/1", smp_valid, n_xfer);
    end
    drive_slot;
    enable = 1'b0;
  endtask

  task automatic test_timeout;
    int c0;
    int bad_valid;
    int i;
    do_reset;
    drive_slot;
    eng_on = 1'b0;
    exp_ch_q.push_back(2'd0);
    exp_ch_q.push_back(2'd1);
    enable = 1'b1;
    wait_start(1, 200);
    checks++;
    if (n_start !== 1) begin
      errors++;
      $display("FAIL tmo_first_start: %0d starts, required 1", n_start);
    end
    c0 = (start_cyc_q.size() > 0) ? start_cyc_q[0] : cyc;
    bad_valid = 0;
    i = 0;
    while (timeout_err !== 1'b1 && i < 1200) begin
      if (smp_valid === 1'b1) bad_valid++;
      @(negedge clk);
      i++;
    end
    checks++;
    if (timeout_err !== 1'b1 || cyc - c0 != 1024) begin
      errors++;
      $display("FAIL tmo_time: timeout_err=%b at %0d cycles after CONVERT entry, required 1 at 1024", timeout_err, cyc - c0);
    end
    checks++;
    if (bad_valid != 0) begin
      errors++;
      $display("FAIL tmo_no_valid: smp_valid high %0d cycles, required 0", bad_valid);
    end
    wait_start(2, 200);
    checks++;
    if (n_start !== 2 || start_cyc_q.size() < 2 || start_cyc_q[start_cyc_q.size()-1] - c0 != 1100) begin
      errors++;
      $display("FAIL tmo_next_start: %0d starts, last %0d cycles after first, required 2 at 1100",
               n_start, (start_cyc_q.size() > 0) ? start_cyc_q[start_cyc_q.size()-1] - c0 : -1);
    end
    checks++;
    if (n_xfer !== 0 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: transfers=%0d timeout_err=%b, required 0/1", n_xfer, timeout_err);
    end
    drive_slot;
    enable = 1'b0;
  endtask

  task automatic test_reset_midop;
    do_reset;
    drive_slot;
    ch_mask   = 4'b0100;
    eng_delay = 150;
    eng_val   = 12'h5A3;
    exp_ch_q.push_back(2'd2);
    exp_ch_q.push_back(2'd2);
    rd_chan = 2'd2;
    enable  = 1'b1;
    wait_start(2, 500);
    repeat (20) @(negedge clk);
    checks++;
    if (conv_chan !== 2'd2 || overrun_cnt !== 8'd1 || rd_valid !== 1'b1 || rd_data !== 12'h5A3) begin
      errors++;
      $display("FAIL midop_pre: chan=%0d overrun=%0d rd_valid=%b rd_data=%h, required 2/1/1/5a3",
               conv_chan, overrun_cnt, rd_valid, rd_data);
    end
    drive_slot;
    rst    = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if (conv_chan !== 2'd0 || overrun_cnt !== 8'd0 || rd_valid !== 1'b0 || rd_data !== 12'h000) begin
      errors++;
      $display("FAIL midop_async_rst: chan=%0d overrun=%0d rd_valid=%b rd_data=%h, required all 0",
               conv_chan, overrun_cnt, rd_valid, rd_data);
    end
    checks++;
    if (conv_start !== 1'b0 || smp_valid !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL midop_async_rst_ctl: start=%b valid=%b tmo=%b, required 0/0/0", conv_start, smp_valid, timeout_err);
    end
    repeat (3) @(negedge clk);
    exp_ch_q.delete();
    exp_smp_q.delete();
    start_cyc_q.delete();
    n_start = 0;
    n_xfer  = 0;
    drive_slot;
    rst       = 1'b1;
    ch_mask   = 4'hF;
    smp_ready = 1'b0;
    exp_ch_q.push_back(2'd0);
    drive_slot;
    enable = 1'b1;
    wait_valid(400);
    checks++;
    if (smp_valid !== 1'b1 || smp_chan !== 2'd0) begin
      errors++;
      $display("FAIL midop_first_chan: valid=%b chan=%0d, required 1/0", smp_valid, smp_chan);
    end
    drive_slot;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    drive_slot;
    smp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (n_xfer !== 1 || smp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_push_done: transfers=%0d valid=%b, required 1/0", n_xfer, smp_valid);
    end
    repeat (300) @(negedge clk);
    checks++;
    if (n_start !== 1) begin
      errors++;
      $display("FAIL midop_idle: %0d starts, required 1", n_start);
    end
  endtask

  task automatic test_overrun;
    do_reset;
    drive_slot;
    eng_delay = 250;
    eng_val   = 12'h0F0;
    for (int i = 0; i < 200; i++) exp_ch_q.push_back(2'(i % 4));
    enable = 1'b1;
    wait_xfer(10, 3500);
    checks++;
    if (n_xfer !== 10 || overrun_cnt !== 8'd20) begin
      errors++;
      $display("FAIL ovr_10: transfers=%0d overrun=%0d, required 10/20", n_xfer, overrun_cnt);
    end
    wait_xfer(127, 36000);
    checks++;
    if (n_xfer !== 127 || overrun_cnt !== 8'd254) begin
      errors++;
      $display("FAIL ovr_127: transfers=%0d overrun=%0d, required 127/254", n_xfer, overrun_cnt);
    end
    wait_xfer(128, 400);
    checks++;
    if (n_xfer !== 128 || overrun_cnt !== 8'd255) begin
      errors++;
      $display("FAIL ovr_128: transfers=%0d overrun=%0d, required 128/255", n_xfer, overrun_cnt);
    end
    wait_xfer(200, 23000);
    checks++;
    if (n_xfer !== 200 || overrun_cnt !== 8'd255) begin
      errors++;
      $display("FAIL ovr_sat: transfers=%0d overrun=%0d, required 200/255", n_xfer, overrun_cnt);
    end
    drive_slot;
    enable = 1'b0;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_mask;
    test_backpressure;
    test_timeout;
    test_reset_midop;
    test_overrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
